// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Package : sram_ctrl_pkg
// Brief   : Shared types and constants for the sram port arbiter slice.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 9;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-way round-robin arbiter; the requester not granted last wins ties.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || (last_q == REQ_B))) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept && (gnt != 2'b00)) begin
      last_d = gnt[1] ? REQ_B : REQ_A;
    end
  end

  // Reset to B so that the first contested grant goes to A.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module : sram_port_arbiter
// Brief  : Shares one single-port sram between requesters A and B with
//          round-robin grant and 1-cycle read response routing.
//          Optional post-reset array clear: define SRAM_CLEAR_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  input  logic [DATA_WIDTH-1:0] a_req_wmask,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_resp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  input  logic [DATA_WIDTH-1:0] b_req_wmask,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_resp_rdata,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [DATA_WIDTH-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  logic                  run;
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [1:0]            gnt;
  logic                  a_pend_q;
  logic                  a_pend_d;
  logic                  b_pend_q;
  logic                  b_pend_d;

`ifdef SRAM_CLEAR_EN
  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d;

  // Counter parks on all-ones; the state change ends the walk, so no wrap.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (&clr_cnt_q) begin
        state_d = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign run      = (state_q == ST_RUN);
  assign clearing = !reset && (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    ({b_req_valid, a_req_valid} & {2{run && !reset}}),
    .accept (|gnt),
    .gnt    (gnt)
  );

  assign a_req_ready = gnt[0];
  assign b_req_ready = gnt[1];

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_waddr = '0;
    sram_raddr = '0;
    sram_din   = '0;
    sram_wmask = '0;
    if (clearing) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_waddr = clr_addr;
      sram_raddr = clr_addr;
      sram_wmask = '1;
    end else if (gnt[0]) begin
      sram_ce    = 1'b1;
      sram_we    = a_req_we;
      sram_waddr = a_req_addr;
      sram_raddr = a_req_addr;
      sram_din   = a_req_wdata;
      sram_wmask = a_req_wmask;
    end else if (gnt[1]) begin
      sram_ce    = 1'b1;
      sram_we    = b_req_we;
      sram_waddr = b_req_addr;
      sram_raddr = b_req_addr;
      sram_din   = b_req_wdata;
      sram_wmask = b_req_wmask;
    end
  end

  // sram_dout is only meaningful the cycle after a granted read; the
  // pending flags alone mark that cycle.
  always_comb begin
    a_pend_d = gnt[0] && !a_req_we;
    b_pend_d = gnt[1] && !b_req_we;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
    end else begin
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
    end
  end

  assign a_resp_valid = a_pend_q && !reset;
  assign b_resp_valid = b_pend_q && !reset;
  assign a_resp_rdata = a_resp_valid ? sram_dout : '0;
  assign b_resp_rdata = b_resp_valid ? sram_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module : tb_sram_port_arbiter
// Brief  : Self-checking bench for sram_port_arbiter (honours SRAM_CLEAR_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_CLEAR_EN
  localparam int CLEAR_CYCLES = DEPTH;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } req_t;

  typedef struct {
    req_t          a;
    req_t          b;
    logic          ar;
    logic          br;
    logic          ce;
    logic          av;
    logic          bv;
    logic [DW-1:0] rd;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [AW-1:0] a_req_addr = '0;
  logic [DW-1:0] a_req_wdata = '0, a_req_wmask = '0;
  logic          b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [AW-1:0] b_req_addr = '0;
  logic [DW-1:0] b_req_wdata = '0, b_req_wmask = '0;
  logic          a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
  logic [DW-1:0] a_resp_rdata, b_resp_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [DW-1:0] sram_din, sram_wmask;
  logic [DW-1:0] sram_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
    .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
    .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_waddr(sram_waddr),
    .sram_raddr(sram_raddr), .sram_din(sram_din), .sram_wmask(sram_wmask),
    .sram_dout(sram_dout)
  );

  // Behavioural single-port sram: masked write, registered read, dout holds when idle.
  logic [DW-1:0] sram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram_mem[i] = '0;
  always @(posedge clock) begin
    if (sram_ce) begin
      if (sram_we) sram_mem[sram_waddr] <= (sram_mem[sram_waddr] & ~sram_wmask) | (sram_din & sram_wmask);
      sram_dout <= sram_mem[sram_raddr];
    end
  end

  // Reference model state.
  logic          m_last = 1'b1;
  logic          m_pa = 1'b0, m_pb = 1'b0;
  logic [DW-1:0] m_da = '0, m_db = '0;
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clear_left = 0;
  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  logic          cap_ar, cap_br, cap_av, cap_bv, cap_ce;
  logic [AW-1:0] cap_waddr;
  logic [DW-1:0] cap_ard, cap_brd, cap_din;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic req_t idle();
    return '{valid: 1'b0, we: 1'b0, addr: '0, wdata: '0, wmask: '0};
  endfunction
  function automatic req_t rd(input logic [AW-1:0] addr);
    return '{valid: 1'b1, we: 1'b0, addr: addr, wdata: '0, wmask: '0};
  endfunction
  function automatic req_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [DW-1:0] m);
    return '{valid: 1'b1, we: 1'b1, addr: addr, wdata: d, wmask: m};
  endfunction
  function automatic vec_t vec(input req_t a, input req_t b, input logic ar, input logic br,
                               input logic ce, input logic av, input logic bv, input logic [DW-1:0] d);
    vec_t v;
    v.a = a; v.b = b; v.ar = ar; v.br = br; v.ce = ce; v.av = av; v.bv = bv; v.rd = d;
    return v;
  endfunction

  // One clock: drive at posedge+1, check at negedge, then advance the model.
  task automatic cycle(input req_t ra, input req_t rb, input logic rst_in);
    logic ga, gb, e_av, e_bv, e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_mask, e_ard, e_brd;
    req_t sel;
    reset = rst_in;
    a_req_valid = ra.valid; a_req_we = ra.we; a_req_addr = ra.addr;
    a_req_wdata = ra.wdata; a_req_wmask = ra.wmask;
    b_req_valid = rb.valid; b_req_we = rb.we; b_req_addr = rb.addr;
    b_req_wdata = rb.wdata; b_req_wmask = rb.wmask;
    ga = 1'b0; gb = 1'b0; e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0; e_mask = '0;
    e_av = m_pa && !rst_in;
    e_bv = m_pb && !rst_in;
    e_ard = e_av ? m_da : '0;
    e_brd = e_bv ? m_db : '0;
    if (!rst_in) begin
      if (m_clear_left > 0) begin
        e_ce = 1'b1; e_we = 1'b1; e_addr = AW'(DEPTH - m_clear_left); e_mask = '1;
      end else begin
        if (ra.valid && rb.valid) begin
          ga = m_last; gb = !m_last;
        end else begin
          ga = ra.valid; gb = rb.valid;
        end
        sel = ga ? ra : rb;
        if (ga || gb) begin
          e_ce = 1'b1; e_we = sel.we; e_addr = sel.addr; e_din = sel.wdata; e_mask = sel.wmask;
        end
      end
    end
    @(negedge clock);
    cap_ar = a_req_ready; cap_br = b_req_ready; cap_av = a_resp_valid; cap_bv = b_resp_valid;
    cap_ard = a_resp_rdata; cap_brd = b_resp_rdata; cap_ce = sram_ce; cap_waddr = sram_waddr;
    cap_din = sram_din;
    chk("a_ready", DW'(a_req_ready), DW'(ga));
    chk("b_ready", DW'(b_req_ready), DW'(gb));
    chk("sram_ce", DW'(sram_ce), DW'(e_ce));
    chk("sram_we", DW'(sram_we), DW'(e_we));
    chk("sram_waddr", DW'(sram_waddr), DW'(e_addr));
    chk("sram_raddr", DW'(sram_raddr), DW'(e_addr));
    chk("sram_din", sram_din, e_din);
    chk("sram_wmask", sram_wmask, e_mask);
    chk("a_resp_valid", DW'(a_resp_valid), DW'(e_av));
    chk("b_resp_valid", DW'(b_resp_valid), DW'(e_bv));
    chk("a_resp_rdata", a_resp_rdata, e_ard);
    chk("b_resp_rdata", b_resp_rdata, e_brd);
    if (rst_in) begin
      m_pa = 1'b0; m_pb = 1'b0; m_last = 1'b1; m_clear_left = CLEAR_CYCLES;
    end else if (m_clear_left > 0) begin
      m_mem[e_addr] = '0; m_clear_left--; m_pa = 1'b0; m_pb = 1'b0;
    end else begin
      m_pa = ga && !ra.we; m_da = m_mem[ra.addr];
      m_pb = gb && !rb.we; m_db = m_mem[rb.addr];
      if (ga || gb) m_last = gb;
      if (e_ce && e_we) m_mem[e_addr] = (m_mem[e_addr] & ~e_mask) | (e_din & e_mask);
    end
    @(posedge clock);
    #1;
  endtask

  localparam logic [DW-1:0] BEEF = 64'h0000_0000_DEAD_BEEF;
  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] MSKD = 64'hFFFF_FFFF_FFFF_FF00;

  vec_t tbl [20];

  initial begin
    tbl[0]  = vec(idle(),                     idle(),             0, 0, 0, 1, 0, '0);
    tbl[1]  = vec(wr(4'd5, BEEF, ONES),       idle(),             1, 0, 1, 0, 0, '0);
    tbl[2]  = vec(rd(4'd5),                   idle(),             1, 0, 1, 0, 0, '0);
    tbl[3]  = vec(idle(),                     idle(),             0, 0, 0, 1, 0, BEEF);
    tbl[4]  = vec(wr(4'd3, ONES, ONES),       idle(),             1, 0, 1, 0, 0, '0);
    tbl[5]  = vec(idle(),                     wr(4'd3, '0, 64'hFF), 0, 1, 1, 0, 0, '0);
    tbl[6]  = vec(idle(),                     rd(4'd3),           0, 1, 1, 0, 0, '0);
    tbl[7]  = vec(idle(),                     idle(),             0, 0, 0, 0, 1, MSKD);
    tbl[8]  = vec(rd(4'd5),                   rd(4'd3),           1, 0, 1, 0, 0, '0);
    tbl[9]  = vec(rd(4'd5),                   rd(4'd3),           0, 1, 1, 1, 0, BEEF);
    tbl[10] = vec(rd(4'd5),                   rd(4'd3),           1, 0, 1, 0, 1, MSKD);
    tbl[11] = vec(rd(4'd5),                   rd(4'd3),           0, 1, 1, 1, 0, BEEF);
    tbl[12] = vec(rd(4'd5),                   rd(4'd3),           1, 0, 1, 0, 1, MSKD);
    tbl[13] = vec(rd(4'd5),                   rd(4'd3),           0, 1, 1, 1, 0, BEEF);
    tbl[14] = vec(idle(),                     idle(),             0, 0, 0, 0, 1, MSKD);
    tbl[15] = vec(idle(),                     rd(4'd5),           0, 1, 1, 0, 0, '0);
    tbl[16] = vec(idle(),                     rd(4'd5),           0, 1, 1, 0, 1, BEEF);
    tbl[17] = vec(idle(),                     rd(4'd5),           0, 1, 1, 0, 1, BEEF);
    tbl[18] = vec(idle(),                     rd(4'd5),           0, 1, 1, 0, 1, BEEF);
    tbl[19] = vec(idle(),                     idle(),             0, 0, 0, 0, 1, BEEF);

    @(posedge clock);
    #1;
    cycle(rd(4'd0), rd(4'd1), 1'b1);
    cycle(rd(4'd0), rd(4'd1), 1'b1);
    chk("reset_a_ready", DW'(cap_ar), '0);
    chk("reset_sram_ce", DW'(cap_ce), '0);

`ifdef SRAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      cycle(rd(4'd0), rd(4'd1), 1'b0);
      chk("clear_a_ready", DW'(cap_ar), '0);
      chk("clear_b_ready", DW'(cap_br), '0);
      chk("clear_waddr", DW'(cap_waddr), DW'(i));
      chk("clear_din", cap_din, '0);
    end
`endif
    // First contested grant after reset (and clear) goes to A.
    cycle(rd(4'd0), rd(4'd1), 1'b0);
    chk("first_grant_a", DW'(cap_ar), 64'd1);
    chk("first_grant_not_b", DW'(cap_br), '0);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].a, tbl[i].b, 1'b0);
      chk($sformatf("vec%0d_a_ready", i), DW'(cap_ar), DW'(tbl[i].ar));
      chk($sformatf("vec%0d_b_ready", i), DW'(cap_br), DW'(tbl[i].br));
      chk($sformatf("vec%0d_ce", i), DW'(cap_ce), DW'(tbl[i].ce));
      chk($sformatf("vec%0d_a_valid", i), DW'(cap_av), DW'(tbl[i].av));
      chk($sformatf("vec%0d_b_valid", i), DW'(cap_bv), DW'(tbl[i].bv));
      chk($sformatf("vec%0d_a_rdata", i), cap_ard, tbl[i].av ? tbl[i].rd : '0);
      chk($sformatf("vec%0d_b_rdata", i), cap_brd, tbl[i].bv ? tbl[i].rd : '0);
    end

    // Reset the cycle after a read accept: the response must be dropped.
    cycle(rd(4'd5), idle(), 1'b0);
    chk("pre_reset_accept", DW'(cap_ar), 64'd1);
    cycle(idle(), idle(), 1'b1);
    chk("reset_drops_resp", DW'(cap_av), '0);
    chk("reset_ce_zero", DW'(cap_ce), '0);
    cycle(idle(), idle(), 1'b0);
    chk("post_reset_no_resp", DW'(cap_av), '0);
`ifdef SRAM_CLEAR_EN
    chk("clear_restart_ce", DW'(cap_ce), 64'd1);
    chk("clear_restart_addr", DW'(cap_waddr), '0);
    for (int i = 1; i < DEPTH; i++) cycle(idle(), idle(), 1'b0);
`else
    chk("post_reset_ce", DW'(cap_ce), '0);
`endif

    for (int n = 0; n < 600; n++) begin
      req_t ra, rb;
      ra.valid = ($urandom_range(0, 3) != 0);
      ra.we    = $urandom_range(0, 1) == 1;
      ra.addr  = AW'($urandom_range(0, 3));
      ra.wdata = {$urandom, $urandom};
      ra.wmask = ($urandom_range(0, 1) == 1) ? ONES : {$urandom, $urandom};
      rb.valid = ($urandom_range(0, 3) != 0);
      rb.we    = $urandom_range(0, 1) == 1;
      rb.addr  = AW'($urandom_range(0, DEPTH - 1));
      rb.wdata = {$urandom, $urandom};
      rb.wmask = ($urandom_range(0, 1) == 1) ? ONES : {$urandom, $urandom};
      cycle(ra, rb, $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
